// File: rtl/sha2_stream.sv
// sha2_stream: streaming SHA-256 block engine with UNROLL rounds per clock and chained multi-block messages.
// SHA-224 mode (IV and truncated digest) is built only when SHA2_SHA224_EN is defined.
module sha2_stream #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         RSTn,
  input  logic         init,
  input  logic         mode,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [31:0]  msg_data,
  input  logic         msg_last,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         busy
);
  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("UNROLL must be 1, 2 or 4");
  end
  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  typedef enum logic [1:0] {IDLE, LOAD, ROUND, UPDATE} state_t;
  state_t state, state_n;
  logic [3:0] wcnt;
  logic [5:0] t;
  logic [31:0] w [16];
  logic [31:0] wn [16];
  logic [0:7][31:0] h, s, v;
  logic first, last_r, fire;
  logic [255:0] iv_in;
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [31:0] bs0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bs1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
`ifdef SHA2_SHA224_EN
  localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  logic mode_r;
  assign iv_in = mode ? IV224 : IV256;
  assign digest = mode_r ? {h[0:6], 32'h0} : h;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign iv_in = IV256;
  assign digest = h;
`endif
  assign fire = msg_valid && msg_ready && !init;
  assign busy = state == ROUND || state == UPDATE;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (fire) state_n = LOAD;
      LOAD:   if (fire && wcnt == 4'd15) state_n = ROUND;
      ROUND:  if (t == 6'(64 - UNROLL)) state_n = UPDATE;
      UPDATE: state_n = IDLE;
    endcase
    if (init) state_n = IDLE;
  end
  // the window w holds W[t..t+15]; ex extends it by the UNROLL words consumed this cycle
  always_comb begin : rnd
    logic [31:0] ex [16+UNROLL];
    logic [31:0] t1, t2;
    for (int i = 0; i < 16; i++) ex[i] = w[i];
    for (int j = 0; j < UNROLL; j++) ex[16+j] = ss1(ex[14+j]) + ex[9+j] + ss0(ex[1+j]) + ex[j];
    for (int i = 0; i < 16; i++) wn[i] = ex[i+UNROLL];
    v = s;
    for (int j = 0; j < UNROLL; j++) begin
      t1 = v[7] + bs1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t + 6'(j)] + ex[j];
      t2 = bs0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v = {t1 + t2, v[0], v[1], v[2], v[3] + t1, v[4], v[5], v[6]};
    end
  end
  always_ff @(posedge clk or negedge RSTn)
    if (!RSTn) begin
      state <= IDLE;
      wcnt <= '0;
      t <= '0;
      msg_ready <= 1'b0;
      digest_valid <= 1'b0;
      first <= 1'b1;
      last_r <= 1'b0;
      h <= IV256;
`ifdef SHA2_SHA224_EN
      mode_r <= 1'b0;
`endif
    end else begin
      state <= state_n;
      msg_ready <= state_n == IDLE || state_n == LOAD;
      if (init) begin
        wcnt <= '0;
        t <= '0;
        digest_valid <= 1'b0;
        first <= 1'b1;
        h <= iv_in;
`ifdef SHA2_SHA224_EN
        mode_r <= mode;
`endif
      end else begin
        if (fire) wcnt <= wcnt + 4'd1;
        if (fire && wcnt == 4'd15) last_r <= msg_last;
        t <= state == ROUND ? t + 6'(UNROLL) : '0;
        if (fire && state == IDLE && first) begin
          h <= iv_in;
          first <= 1'b0;
          digest_valid <= 1'b0;
`ifdef SHA2_SHA224_EN
          mode_r <= mode;
`endif
        end
        if (state == UPDATE) begin
          for (int i = 0; i < 8; i++) h[i] <= h[i] + s[i];
          if (last_r) begin
            digest_valid <= 1'b1;
            first <= 1'b1;
          end
        end
      end
    end
  always_ff @(posedge clk) begin
    if (fire) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= msg_data;
    end else if (state == ROUND) w <= wn;
    if (state == LOAD && state_n == ROUND) s <= h;
    else if (state == ROUND) s <= v;
  end
endmodule

// File: tb/tb_sha2_stream.sv
// tb_sha2_stream: directed vectors plus randomized multi-block messages with gaps, checked against a FIPS 180-4 model.
module tb_sha2_stream;
  parameter int UNROLL = 1;
  localparam int LAT = 64 / UNROLL + 1;
  localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
  localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] TWO256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [31:0] TWO_BLK [16] = '{
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
  };
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  logic clk = 1'b0, RSTn = 1'b0, init = 1'b0, mode = 1'b0, msg_valid = 1'b0, msg_last = 1'b0;
  logic [31:0] msg_data = '0;
  logic msg_ready, digest_valid, busy;
  logic [255:0] digest;
  logic [31:0] mw [64];
  int tests = 0, fails = 0;
  sha2_stream #(.UNROLL(UNROLL)) dut (
    .clk(clk), .RSTn(RSTn), .init(init), .mode(mode), .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data(msg_data), .msg_last(msg_last), .digest(digest), .digest_valid(digest_valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  // one FIPS 180-4 compression of block b of mw onto chaining value hin
  function automatic logic [255:0] compress(input logic [255:0] hin, input int b);
    logic [31:0] ws [64];
    logic [31:0] a, bb, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 64; i++)
      if (i < 16) ws[i] = mw[16*b+i];
      else ws[i] = (rr(ws[i-2], 17) ^ rr(ws[i-2], 19) ^ (ws[i-2] >> 10)) + ws[i-7]
                 + (rr(ws[i-15], 7) ^ rr(ws[i-15], 18) ^ (ws[i-15] >> 3)) + ws[i-16];
    {a, bb, c, d, e, f, g, hh} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + ws[i];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & bb) ^ (a & c) ^ (bb & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = bb; bb = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + bb, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + hh};
  endfunction
  task automatic set_abc();
    for (int i = 0; i < 64; i++) mw[i] = '0;
    mw[0] = 32'h61626380;
    mw[15] = 32'h00000018;
  endtask
  task automatic set_two();
    for (int i = 0; i < 64; i++) mw[i] = i < 16 ? TWO_BLK[i] : 32'h0;
    mw[31] = 32'h000001c0;
  endtask
  task automatic send_word(input logic [31:0] d, input logic lst, input logic md, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      msg_valid = 1'b0;
      msg_data = $urandom;
      step();
    end
    msg_data = d;
    msg_last = lst;
    mode = md;
    msg_valid = 1'b1;
    n = 0;
    while (msg_ready !== 1'b1 && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) check("ready_timeout", msg_ready, 1);
    step();
    msg_valid = 1'b0;
    msg_data = $urandom;
    msg_last = 1'($urandom);
    mode = 1'($urandom);
  endtask
  task automatic wait_done(output int lat);
    lat = 0;
    while (msg_ready !== 1'b1 && lat < 200) begin
      step();
      lat++;
    end
  endtask
  task automatic send_msg(input int nblk, input logic md, input bit gaps, input string tag);
    logic [255:0] hm;
    logic em;
    int lat;
`ifdef SHA2_SHA224_EN
    em = md;
`else
    em = 1'b0;
`endif
    hm = em ? IV224 : IV256;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 16; i++) begin
        send_word(mw[16*b+i], i == 15 ? b == nblk - 1 : 1'($urandom), b == 0 && i == 0 ? md : 1'($urandom), gaps);
        if (b == 0 && i == 0) check($sformatf("%s_dv_clear", tag), digest_valid, 0);
      end
      check($sformatf("%s_b%0d_busy_ready", tag, b), {busy, msg_ready}, 2'b10);
      wait_done(lat);
      hm = compress(hm, b);
      check($sformatf("%s_b%0d_latency", tag, b), lat, LAT);
      check($sformatf("%s_b%0d_dv", tag, b), digest_valid, b == nblk - 1);
      check($sformatf("%s_b%0d_digest", tag, b), digest, em ? {hm[255:32], 32'h0} : hm);
    end
  endtask
  initial begin
    int lat;
    repeat (2) step();
    check("rst_ready", msg_ready, 0);
    check("rst_dv", digest_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_digest", digest, IV256);
    RSTn = 1'b1;
    step();
    check("rst_ready_rise", msg_ready, 1);
    set_abc();
    send_msg(1, 1'b0, 1'b0, "abc256");
    check("abc256_const", digest, ABC256);
    send_msg(1, 1'b1, 1'b0, "abc_mode1");
`ifdef SHA2_SHA224_EN
    check("abc224_const", digest, ABC224);
`else
    check("abc_mode_ignored", digest, ABC256);
`endif
    set_two();
    send_msg(2, 1'b0, 1'b0, "two");
    check("two_const", digest, TWO256);
    set_abc();
    for (int i = 0; i < 8; i++) send_word(mw[i], 1'b0, 1'b0, 1'b0);
    init = 1'b1;
    mode = 1'b0;
    msg_valid = 1'b1;
    msg_data = $urandom;
    step();
    init = 1'b0;
    msg_valid = 1'b0;
    check("init_load_ready", msg_ready, 1);
    check("init_load_busy", busy, 0);
    check("init_load_digest", digest, IV256);
    send_msg(1, 1'b0, 1'b1, "init_abc");
    check("init_abc_const", digest, ABC256);
    for (int i = 0; i < 16; i++) send_word(mw[i], i == 15, 1'b0, 1'b0);
    repeat (3) step();
    check("round_busy", busy, 1);
    init = 1'b1;
    mode = 1'b0;
    step();
    init = 1'b0;
    check("init_round_busy", busy, 0);
    check("init_round_ready", msg_ready, 1);
    check("init_round_dv", digest_valid, 0);
    check("init_round_digest", digest, IV256);
    send_msg(1, 1'b0, 1'b0, "b2b_first");
    send_msg(1, 1'b0, 1'b0, "b2b_second");
    check("b2b_const", digest, ABC256);
    for (int r = 0; r < 6; r++) begin
      int nb;
      nb = $urandom_range(1, 3);
      for (int i = 0; i < 16 * nb; i++) mw[i] = $urandom;
      send_msg(nb, 1'($urandom), 1'b1, $sformatf("rnd%0d", r));
    end
    set_two();
    for (int i = 0; i < 16; i++) send_word(mw[i], 1'b0, 1'b0, 1'b0);
    wait_done(lat);
    for (int i = 0; i < 5; i++) send_word(mw[16+i], 1'b0, 1'b0, 1'b0);
    RSTn = 1'b0;
    #1;
    check("midrst_ready", msg_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_dv", digest_valid, 0);
    check("midrst_digest", digest, IV256);
    step();
    RSTn = 1'b1;
    step();
    check("midrst_ready_rise", msg_ready, 1);
    set_abc();
    send_msg(1, 1'b0, 1'b1, "after_rst");
    check("after_rst_const", digest, ABC256);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
